vga_hline_vram_scan: RTL and testbench

- Horizontal VGA scan engine with an integrated 128x96, 3-bit-per-pixel video RAM.
- Runs from a 100 MHz system clock. Generates 640x480@60 horizontal timing at a 25 MHz pixel rate, with each RAM column stretched to 5 screen pixels.
- Reads the RAM row selected by an external row index and drives HSYNC plus 1-bit R/G/B to the VGA connector.
- Sits between the vertical timing block (which supplies the row) and the board VGA pins.

---
 rtl/vga_hline_vram_scan.sv | 121 ++++++++++++
 tb/tb_vga_hline_vram_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_hline_vram_scan.sv
// Horizontal VGA scan engine with an integrated 128x96 x 3-bit video RAM.
// The engine produces 640x480@60 horizontal timing from a 100 MHz clock.
// Each RAM column is stretched to PIX_PER_COL screen pixels.
// The outputs (hsync, rgb, colour) are registered one clock behind hpixel, so
// they line up with the synchronous RAM read.
module vga_hline_vram_scan #(
  parameter int unsigned CLK_PER_PIX = 4,
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned PIX_PER_COL = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] vpixel,
  output logic [6:0] hpixel,
  output logic       hsync,
  output logic       rgb,
  output logic       vga_red,
  output logic       vga_green,
  output logic       vga_blue
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_ROWS  = 96;
  localparam int unsigned PW      = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned CW      = (PIX_PER_COL > 1) ? $clog2(PIX_PER_COL) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_PER_PIX - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP_END = HW'(H_DISPLAY);
  localparam logic [HW-1:0] SYNC_BEG   = HW'(H_DISPLAY + H_FP);
  localparam logic [HW-1:0] SYNC_END   = HW'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [CW-1:0] COL_LAST   = CW'(PIX_PER_COL - 1);
  localparam logic [6:0]    ROW_LIMIT  = 7'(V_ROWS);

  logic [PW-1:0] pre_q,  pre_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] col_q,  col_d;
  logic [6:0]    hpix_q, hpix_d;
  logic          hsync_q, hsync_d;
  logic          rgb_q,   rgb_d;
  logic [2:0]    colour_q, colour_d;

  logic tick;
  logic in_disp;
  logic sync_act;
  logic row_ok;

  // The video RAM has no write port, so it only ever holds its power-up image.
  // Word {row r, column c} is c[6:4] ^ r[6:4], and {vpixel, hpixel} selects it.
  // The read below stays a 1-clock registered lookup of that image.
  function automatic logic [2:0] vram_word(input logic [6:0] row, input logic [6:0] col);
    return col[6:4] ^ row[6:4];
  endfunction

  // Next-state logic: prescaler, line counter, column sub-counter and aligned outputs
  always_comb begin
    tick     = (pre_q == PRE_LAST);
    in_disp  = (hcnt_q < H_DISP_END);
    sync_act = (hcnt_q >= SYNC_BEG) && (hcnt_q < SYNC_END);
    row_ok   = (vpixel < ROW_LIMIT);

    pre_d  = tick ? '0 : pre_q + 1'b1;
    hcnt_d = hcnt_q;
    col_d  = col_q;
    hpix_d = hpix_q;

    if (tick) begin
      hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
      if (in_disp) begin
        if (col_q == COL_LAST) begin
          col_d  = '0;
          hpix_d = hpix_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
    if (!in_disp) begin
      col_d  = '0;
      hpix_d = '0;
    end

    // The output group samples the current hcount/hpixel, so it lands one clock behind hpixel
    hsync_d  = !sync_act;
    rgb_d    = in_disp;
    colour_d = (in_disp && row_ok) ? vram_word(vpixel, hpix_q) : '0;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q    <= '0;
      hcnt_q   <= '0;
      col_q    <= '0;
      hpix_q   <= '0;
      hsync_q  <= 1'b1;
      rgb_q    <= 1'b0;
      colour_q <= '0;
    end else begin
      pre_q    <= pre_d;
      hcnt_q   <= hcnt_d;
      col_q    <= col_d;
      hpix_q   <= hpix_d;
      hsync_q  <= hsync_d;
      rgb_q    <= rgb_d;
      colour_q <= colour_d;
    end
  end

  assign hpixel    = hpix_q;
  assign hsync     = hsync_q;
  assign rgb       = rgb_q;
  assign vga_red   = colour_q[2];
  assign vga_green = colour_q[1];
  assign vga_blue  = colour_q[0];

endmodule

// File: tb/tb_vga_hline_vram_scan.sv
// Bench for vga_hline_vram_scan: randomized vpixel checked against a line-position model.
module tb_vga_hline_vram_scan;

  logic       clk;
  logic       reset;
  logic [6:0] vpixel;
  logic [6:0] hpixel;
  logic       hsync;
  logic       rgb;
  logic       vga_red;
  logic       vga_green;
  logic       vga_blue;

  int checks = 0;
  int errors = 0;

  int t;          // clock edges since reset release
  int vp_cur;     // vpixel value the DUT will sample at the next edge
  int prev_hs;
  int first_fall;
  int last_fall;
  int rgb_cnt;

  vga_hline_vram_scan #(
    .CLK_PER_PIX(4),
    .H_DISPLAY(640),
    .H_FP(16),
    .H_SYNC(96),
    .H_BP(48),
    .PIX_PER_COL(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vpixel(vpixel),
    .hpixel(hpixel),
    .hsync(hsync),
    .rgb(rgb),
    .vga_red(vga_red),
    .vga_green(vga_green),
    .vga_blue(vga_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  // Reference: a line is 3200 clocks, 20 clocks per column over the first 2560.
  function automatic int exp_hpix(input int tt);
    int p;
    p = tt % 3200;
    return (p < 2560) ? p / 20 : 0;
  endfunction

  // The output group shows the line position one clock earlier.
  function automatic int exp_rgb(input int tt);
    if (tt == 0) return 0;
    return (((tt - 1) % 3200) / 4 < 640) ? 1 : 0;
  endfunction

  function automatic int exp_hsync(input int tt);
    int hc;
    if (tt == 0) return 1;
    hc = ((tt - 1) % 3200) / 4;
    return (hc >= 656 && hc < 752) ? 0 : 1;
  endfunction

  function automatic int exp_colour(input int tt, input int vp);
    int col;
    if (tt == 0 || exp_rgb(tt) == 0 || vp >= 96) return 0;
    col = exp_hpix(tt - 1);
    return ((col / 16) ^ (vp / 16)) & 7;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hpixel"}, int'(hpixel), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_colour"}, int'({vga_red, vga_green, vga_blue}), 0);
  endtask

  task automatic clear_tracking();
    prev_hs    = 1;
    first_fall = 1;
    last_fall  = 0;
    rgb_cnt    = 0;
  endtask

  // mode 0: hold vpixel; mode 1: random vpixel changes, including mid-line
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
      chk("hpixel", int'(hpixel), exp_hpix(t));
      chk("rgb", int'(rgb), exp_rgb(t));
      chk("hsync", int'(hsync), exp_hsync(t));
      chk("colour", int'({vga_red, vga_green, vga_blue}), exp_colour(t, vp_cur));

      if (rgb) rgb_cnt++;
      if (t % 3200 == 0) begin
        chk("rgb_per_line", rgb_cnt, 2560);
        rgb_cnt = 0;
      end

      if (prev_hs == 1 && hsync == 1'b0) begin
        if (first_fall == 1) chk("first_fall", t, 2625);
        else chk("fall_spacing", t - last_fall, 3200);
        first_fall = 0;
        last_fall  = t;
      end else if (prev_hs == 0 && hsync == 1'b1) begin
        chk("low_width", t - last_fall, 384);
      end
      prev_hs = int'(hsync);

      if (mode == 1 && ($urandom_range(0, 49) == 0 || t % 3200 == 0)) begin
        vp_cur = int'($urandom_range(0, 127));
        vpixel = 7'(vp_cur);
      end
    end
  endtask

  task automatic set_vp(input int v);
    vp_cur = v;
    vpixel = 7'(v);
  endtask

  initial begin
    t = 0;
    clear_tracking();
    reset = 1'b0;
    set_vp(0);

    // Hold reset for 12 clocks
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check_reset_vals("rst_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    t = 0;
    #1;
    check_reset_vals("rel");

    // Line with row 0, then row 16, then an out-of-range row
    run_cycles(3200, 0);
    set_vp(16);
    run_cycles(3200, 0);
    set_vp(100);
    run_cycles(3200, 0);
    // Random rows, changing at line starts and mid-line
    run_cycles(3 * 3200, 1);

    // Mid-line reset at clock 1000 of a line
    set_vp(16);
    run_cycles(1000, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_vals("midline_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    t = 0;
    clear_tracking();
    #1;
    check_reset_vals("rel2");
    run_cycles(3200 + 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
